// File: rtl/sd_pkg.sv
// Shared SD definitions: receiver state encoding, sector/CRC constants and card
// type codes used by both the data reader and the command FSM.
package sd_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_WAIT_START,
    RX_DATA,
    RX_CRC,
    RX_END,
    RX_DONE
  } rx_state_t;

  localparam int unsigned SD_SECTOR_BYTES = 512;
  localparam int unsigned SD_CRC_BITS     = 16;
  localparam logic [15:0] SD_CRC16_POLY   = 16'h1021;

  typedef enum logic [1:0] {
    CARD_UNKNOWN,
    CARD_SDV1,
    CARD_SDV2,
    CARD_SDHCV2
  } card_type_t;

endpackage

// File: rtl/sd_dat_reader_if.sv
// Bundle between the SD data reader and its controller: SD lines, transfer
// control and the byte stream towards the user side.
interface sd_dat_reader_if #(
  parameter int unsigned DAT_WIDTH    = 1,
  parameter int unsigned MAX_BLOCKS_W = 16
);
  logic                    sdclk;
  logic [DAT_WIDTH-1:0]    sddat;
  logic                    start;
  logic [MAX_BLOCKS_W-1:0] nblocks;
  logic                    abort;
  logic                    busy;
  logic                    done;
  logic                    stop_req;
  logic                    err_timeout;
  logic                    err_crc;
  logic                    blk_done;
  logic [MAX_BLOCKS_W-1:0] blk_idx;
  logic                    outen;
  logic [8:0]              outaddr;
  logic [7:0]              outbyte;

  modport master (
    output sdclk, sddat, start, nblocks, abort,
    input  busy, done, stop_req, err_timeout, err_crc, blk_done, blk_idx,
           outen, outaddr, outbyte
  );

  modport slave (
    input  sdclk, sddat, start, nblocks, abort,
    output busy, done, stop_req, err_timeout, err_crc, blk_done, blk_idx,
           outen, outaddr, outbyte
  );
endinterface

// File: rtl/sd_crc16.sv
// Bit-serial CRC16 (x^16+x^12+x^5+1, init 0) for one DAT lane.
module sd_crc16
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;
  logic        w_fb;

  assign w_fb  = i_bit ^ r_crc[15];
  assign o_crc = r_crc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc <= '0;
    end else if (i_clr) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? SD_CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/sd_dat_reader.sv
// SD data-phase receiver: 1/4-bit DAT, multi-block reads, per-lane CRC16 check,
// start-bit timeout; streams sector bytes with their offset and block index.
module sd_dat_reader
  import sd_pkg::*;
#(
  parameter int unsigned DAT_WIDTH    = 1,
  parameter int unsigned TIMEOUT_CLKS = 1000000,
  parameter int unsigned MAX_BLOCKS_W = 16
) (
  input logic             clk,
  input logic             rst,
  sd_dat_reader_if.slave  bus
);

  localparam int unsigned LANE_BITS = SD_SECTOR_BYTES * 8 / DAT_WIDTH;
  localparam int unsigned SUB_W     = $clog2(8 / DAT_WIDTH);
  localparam int unsigned BITCNT_W  = $clog2(LANE_BITS);
  localparam int unsigned TMO_W     = $clog2(TIMEOUT_CLKS + 1);

  rx_state_t               r_state;
  logic                    r_sdclkl;
  logic [7-DAT_WIDTH:0]    r_shift;
  logic [BITCNT_W-1:0]     r_bitcnt;
  logic [TMO_W-1:0]        r_tmo;
  logic [MAX_BLOCKS_W-1:0] r_count;
  logic [MAX_BLOCKS_W-1:0] r_blk_idx;
  logic [8:0]              r_addr;
  logic                    r_busy, r_done, r_stop_req, r_err_timeout, r_err_crc;
  logic                    r_blk_done, r_outen;
  logic [8:0]              r_outaddr;
  logic [7:0]              r_outbyte;

  logic                    w_edge;
  logic [7:0]              w_shift_next;
  logic                    w_crc_clr, w_crc_en;
  logic [3:0]              w_crc_sel;
  logic [15:0]             w_crc [DAT_WIDTH];
  logic [DAT_WIDTH-1:0]    w_lane_err;

  assign w_edge       = ~r_sdclkl & bus.sdclk;
  assign w_shift_next = {r_shift, bus.sddat};
  assign w_crc_clr    = w_edge & (r_state == RX_WAIT_START) & ~bus.sddat[0];
  assign w_crc_en     = w_edge & (r_state == RX_DATA);
  assign w_crc_sel    = 4'(SD_CRC_BITS - 1) - r_bitcnt[3:0];

  // One CRC engine per lane; during the CRC phase each lane's incoming bit is
  // compared against the matching bit of its own accumulated CRC.
  for (genvar g = 0; g < DAT_WIDTH; g++) begin : g_lane
    sd_crc16 u_crc (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_crc_clr),
      .i_en  (w_crc_en),
      .i_bit (bus.sddat[g]),
      .o_crc (w_crc[g])
    );
    assign w_lane_err[g] = bus.sddat[g] ^ w_crc[g][w_crc_sel];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RX_IDLE;
      r_sdclkl      <= 1'b0;
      r_shift       <= '0;
      r_bitcnt      <= '0;
      r_tmo         <= '0;
      r_count       <= '0;
      r_blk_idx     <= '0;
      r_addr        <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_stop_req    <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_crc     <= 1'b0;
      r_blk_done    <= 1'b0;
      r_outen       <= 1'b0;
      r_outaddr     <= '0;
      r_outbyte     <= '0;
    end else begin
      r_sdclkl   <= bus.sdclk;
      r_outen    <= 1'b0;
      r_done     <= 1'b0;
      r_stop_req <= 1'b0;
      r_blk_done <= 1'b0;
      if (bus.abort) begin
        r_state <= RX_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          RX_IDLE: if (bus.start) begin
            r_count       <= (bus.nblocks == '0) ? MAX_BLOCKS_W'(1) : bus.nblocks;
            r_err_timeout <= 1'b0;
            r_err_crc     <= 1'b0;
            r_blk_idx     <= '0;
            r_tmo         <= '0;
            r_addr        <= '0;
            r_busy        <= 1'b1;
            r_state       <= RX_WAIT_START;
          end
          RX_WAIT_START: if (w_edge) begin
            if (!bus.sddat[0]) begin
              r_bitcnt <= '0;
              r_state  <= RX_DATA;
            end else if (32'(r_tmo) >= TIMEOUT_CLKS) begin
              r_err_timeout <= 1'b1;
              r_state       <= RX_DONE;
            end else begin
              r_tmo <= r_tmo + TMO_W'(1);
            end
          end
          RX_DATA: if (w_edge) begin
            r_shift  <= w_shift_next[7-DAT_WIDTH:0];
            r_bitcnt <= r_bitcnt + BITCNT_W'(1);
            if (&r_bitcnt[SUB_W-1:0]) begin
              r_outen   <= 1'b1;
              r_outaddr <= r_addr;
              r_outbyte <= w_shift_next;
              r_addr    <= r_addr + 9'd1;
            end
            if (r_bitcnt == BITCNT_W'(LANE_BITS - 1)) begin
              r_bitcnt <= '0;
              r_state  <= RX_CRC;
            end
          end
          RX_CRC: if (w_edge) begin
            if (|w_lane_err) r_err_crc <= 1'b1;
            r_bitcnt <= r_bitcnt + BITCNT_W'(1);
            if (r_bitcnt == BITCNT_W'(SD_CRC_BITS - 1)) r_state <= RX_END;
          end
          RX_END: if (w_edge) begin
            if (r_err_crc) begin
              r_state <= RX_DONE;
            end else begin
              r_blk_done <= 1'b1;
              if (r_blk_idx + MAX_BLOCKS_W'(1) == r_count) begin
                r_state <= RX_DONE;
              end else begin
                r_blk_idx <= r_blk_idx + MAX_BLOCKS_W'(1);
                r_tmo     <= '0;
                r_state   <= RX_WAIT_START;
              end
            end
          end
          RX_DONE: begin
            r_done     <= 1'b1;
            r_stop_req <= (r_count > MAX_BLOCKS_W'(1));
            r_busy     <= 1'b0;
            r_state    <= RX_IDLE;
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.stop_req    = r_stop_req;
  assign bus.err_timeout = r_err_timeout;
  assign bus.err_crc     = r_err_crc;
  assign bus.blk_done    = r_blk_done;
  assign bus.blk_idx     = r_blk_idx;
  assign bus.outen       = r_outen;
  assign bus.outaddr     = r_outaddr;
  assign bus.outbyte     = r_outbyte;

endmodule

// File: tb/tb_sd_dat_reader.sv
// Directed/random bench for sd_dat_reader: a 1-bit and a 4-bit instance share the
// stimulus; expected bytes and CRCs come from a sector/long-division model.
module tb_sd_dat_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        sdclk;
  logic [3:0]  dat;
  logic        start;
  logic        abort;
  logic [15:0] nblk;
  bit          sel;

  always #5 clk = ~clk;

  sd_dat_reader_if #(.DAT_WIDTH(1), .MAX_BLOCKS_W(16)) if1 ();
  sd_dat_reader_if #(.DAT_WIDTH(4), .MAX_BLOCKS_W(16)) if4 ();

  assign if1.sdclk   = sdclk;
  assign if1.sddat   = dat[0];
  assign if1.start   = start & ~sel;
  assign if1.nblocks = nblk;
  assign if1.abort   = abort;
  assign if4.sdclk   = sdclk;
  assign if4.sddat   = dat;
  assign if4.start   = start & sel;
  assign if4.nblocks = nblk;
  assign if4.abort   = abort;

  sd_dat_reader #(.DAT_WIDTH(1), .TIMEOUT_CLKS(100), .MAX_BLOCKS_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave));
  sd_dat_reader #(.DAT_WIDTH(4), .TIMEOUT_CLKS(100), .MAX_BLOCKS_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .bus(if4.slave));

  // Outputs of whichever instance is currently under test.
  logic        m_busy, m_done, m_stop, m_errt, m_errc, m_blkdone, m_outen;
  logic [15:0] m_blk_idx;
  logic [8:0]  m_outaddr;
  logic [7:0]  m_outbyte;
  assign m_busy    = sel ? if4.busy        : if1.busy;
  assign m_done    = sel ? if4.done        : if1.done;
  assign m_stop    = sel ? if4.stop_req    : if1.stop_req;
  assign m_errt    = sel ? if4.err_timeout : if1.err_timeout;
  assign m_errc    = sel ? if4.err_crc     : if1.err_crc;
  assign m_blkdone = sel ? if4.blk_done    : if1.blk_done;
  assign m_outen   = sel ? if4.outen       : if1.outen;
  assign m_blk_idx = sel ? if4.blk_idx     : if1.blk_idx;
  assign m_outaddr = sel ? if4.outaddr     : if1.outaddr;
  assign m_outbyte = sel ? if4.outbyte     : if1.outbyte;

  logic [31:0] q_obs[$];
  int          n_blkdone = 0, n_done = 0, n_stop = 0;

  always @(negedge clk) begin
    if (m_outen) q_obs.push_back({8'(m_blk_idx), 7'd0, m_outaddr, m_outbyte});
    if (m_blkdone) n_blkdone++;
    if (m_done) n_done++;
    if (m_stop) n_stop++;
  end

  int          n_pass = 0, n_fail = 0, n_total = 0;
  logic [31:0] q_exp[$];
  logic [7:0]  blk_data [512];
  int          base, bd0, d0, s0, edges;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_edge(input logic [3:0] v);
    dat   = v;
    sdclk = 1'b0;
    tick; tick;
    sdclk = 1'b1;
    tick; tick;
  endtask

  // CRC16 as remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
  function automatic logic [15:0] crc_div(input bit msg[$]);
    bit          m[$];
    logic [16:0] gen;
    logic [15:0] r;
    gen = 17'h11021;
    m   = msg;
    for (int k = 0; k < 16; k++) m.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++)
      if (m[i]) for (int k = 0; k < 17; k++) m[i+k] = m[i+k] ^ gen[5'(16 - k)];
    for (int k = 0; k < 16; k++) r[4'(15 - k)] = m[msg.size() + k];
    return r;
  endfunction

  // Bit carried by lane j on data edge t of the current sector.
  function automatic bit lane_bit(input bit w4, input int j, input int t);
    logic [7:0] b;
    if (!w4) begin
      b = blk_data[9'(t / 8)];
      return b[3'(7 - (t % 8))];
    end
    b = blk_data[9'(t / 2)];
    return b[3'((((t % 2) == 0) ? 4 : 0) + j)];
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < 512; i++)
      blk_data[i] = (mode == 0) ? 8'hFF : (mode == 1) ? 8'(i) : 8'($urandom);
  endtask

  task automatic send_block(input int b, input int gap, input int nbytes, input bit fix_en,
                            input logic [15:0] fix_crc, input logic [15:0] crc_xor);
    logic [15:0] crc [4];
    bit          q[$];
    logic [3:0]  v;
    int          nl, eb;
    nl = sel ? 4 : 1;
    eb = sel ? 2 : 8;
    for (int j = 0; j < 4; j++) begin
      crc[j] = 16'h0;
      if (j < nl) begin
        q.delete();
        for (int t = 0; t < 512 * eb; t++) q.push_back(lane_bit(sel, j, t));
        crc[j] = crc_div(q);
      end
    end
    if (fix_en) crc[0] = fix_crc;
    crc[0] = crc[0] ^ crc_xor;
    repeat (gap) do_edge(4'hF);
    do_edge(4'h0);
    for (int t = 0; t < nbytes * eb; t++) begin
      v = 4'hF;
      for (int j = 0; j < nl; j++) v[2'(j)] = lane_bit(sel, j, t);
      do_edge(v);
      if ((t % eb) == eb - 1)
        q_exp.push_back({8'(b), 7'd0, 9'(t / eb), blk_data[9'(t / eb)]});
    end
    if (nbytes == 512) begin
      for (int k = 15; k >= 0; k--) begin
        v = 4'hF;
        for (int j = 0; j < nl; j++) v[2'(j)] = crc[j][4'(k)];
        do_edge(v);
      end
      do_edge(4'hF);
    end
  endtask

  task automatic begin_test;
    q_exp.delete();
    base = q_obs.size();
    bd0  = n_blkdone;
    d0   = n_done;
    s0   = n_stop;
  endtask

  task automatic start_xfer(input string tag, input logic [15:0] n);
    nblk  = n;
    start = 1'b1;
    tick;
    start = 1'b0;
    check({tag, "_busy_on_start"}, 32'(m_busy), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20 && n_done == d0; i++) tick;
    tick; tick;
    check({tag, "_done_pulses"}, 32'(n_done - d0), 32'd1);
    check({tag, "_busy_after"}, 32'(m_busy), 32'd0);
  endtask

  task automatic verify_stream(input string tag);
    int got;
    got = q_obs.size() - base;
    check({tag, "_byte_count"}, 32'(got), 32'(q_exp.size()));
    for (int i = 0; i < q_exp.size() && i < got; i++)
      check({tag, "_byte"}, q_obs[base + i], q_exp[i]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_flags"}, 32'({m_busy, m_done, m_stop, m_errt, m_errc, m_blkdone, m_outen}), 32'd0);
    check({tag, "_blk_idx"}, 32'(m_blk_idx), 32'd0);
    check({tag, "_out"}, 32'({m_outaddr, m_outbyte}), 32'd0);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; start = 1'b0; abort = 1'b0;
    dat = 4'hF; sdclk = 1'b0; nblk = 16'd1;
    repeat (3) tick;
    check_zero("reset_w1");
    sel = 1'b1;
    check_zero("reset_w4");
    rst = 1'b0;
    tick;

    // 1-bit, single all-ones sector with the well-known CRC 0x7FA1
    sel = 1'b0; begin_test; fill(0);
    start_xfer("t1", 16'd1);
    send_block(0, 20, 512, 1'b1, 16'h7FA1, 16'h0);
    wait_done("t1");
    verify_stream("t1");
    check("t1_blk_done", 32'(n_blkdone - bd0), 32'd1);
    check("t1_stop_req", 32'(n_stop - s0), 32'd0);
    check("t1_errs", 32'({m_errt, m_errc}), 32'd0);

    // 4-bit, three sectors of incrementing bytes; a start while busy is ignored
    sel = 1'b1; begin_test; fill(1);
    start_xfer("t2", 16'd3);
    for (int b = 0; b < 3; b++) begin
      send_block(b, 3 + b, 512, 1'b0, 16'h0, 16'h0);
      if (b == 0) begin
        nblk = 16'd1; start = 1'b1; tick; start = 1'b0;
        check("t2_busy_hold", 32'(m_busy), 32'd1);
      end
    end
    wait_done("t2");
    verify_stream("t2");
    check("t2_blk_done", 32'(n_blkdone - bd0), 32'd3);
    check("t2_stop_req", 32'(n_stop - s0), 32'd1);
    check("t2_errs", 32'({m_errt, m_errc}), 32'd0);

    // 1-bit, first of two sectors has a corrupted CRC bit
    sel = 1'b0; begin_test; fill(2);
    start_xfer("t3", 16'd2);
    send_block(0, 5, 512, 1'b0, 16'h0, 16'h0100);
    wait_done("t3");
    verify_stream("t3");
    check("t3_err_crc", 32'(m_errc), 32'd1);
    check("t3_blk_done", 32'(n_blkdone - bd0), 32'd0);
    check("t3_stop_req", 32'(n_stop - s0), 32'd1);
    repeat (3) do_edge(4'hF);
    do_edge(4'h0);
    for (int t = 0; t < 64; t++) do_edge(4'($urandom));
    check("t3_no_block1", 32'(q_obs.size() - base), 32'(q_exp.size()));
    check("t3_done_once", 32'(n_done - d0), 32'd1);

    // 4-bit, DAT held high: timeout on the 101st edge
    sel = 1'b1; begin_test;
    start_xfer("t4", 16'd1);
    edges = 0;
    for (int e = 1; e <= 200; e++) begin
      do_edge(4'hF);
      if (n_done != d0) begin edges = e; break; end
    end
    check("t4_edges_to_done", 32'(edges), 32'd101);
    check("t4_err_timeout", 32'(m_errt), 32'd1);
    check("t4_err_crc", 32'(m_errc), 32'd0);
    check("t4_no_outen", 32'(q_obs.size() - base), 32'd0);
    check("t4_stop_req", 32'(n_stop - s0), 32'd0);
    check("t4_blk_done", 32'(n_blkdone - bd0), 32'd0);

    // 4-bit, abort at byte 200 of block 1 of 4
    begin_test; fill(2);
    start_xfer("t5", 16'd4);
    check("t5_err_cleared", 32'(m_errt), 32'd0);
    send_block(0, 2, 512, 1'b0, 16'h0, 16'h0);
    fill(2);
    send_block(1, 2, 200, 1'b0, 16'h0, 16'h0);
    abort = 1'b1; tick; abort = 1'b0;
    check("t5_busy_after_abort", 32'(m_busy), 32'd0);
    for (int t = 0; t < 8; t++) do_edge(4'($urandom));
    verify_stream("t5");
    check("t5_no_done", 32'(n_done - d0), 32'd0);
    check("t5_no_stop", 32'(n_stop - s0), 32'd0);
    check("t5_blk_done", 32'(n_blkdone - bd0), 32'd1);
    abort = 1'b1; start = 1'b1; tick; abort = 1'b0; start = 1'b0;
    check("t5_abort_wins", 32'(m_busy), 32'd0);
    begin_test;
    start_xfer("t5_restart", 16'd1);
    check("t5_restart_errs", 32'({m_errt, m_errc}), 32'd0);

    // 4-bit, async reset in the middle of DATA, then a clean single sector
    send_block(0, 1, 50, 1'b0, 16'h0, 16'h0);
    verify_stream("t6_partial");
    #2 rst = 1'b1;
    #1 check_zero("t6_async_rst");
    tick; rst = 1'b0; tick;
    check_zero("t6_after_rst");
    check("t6_no_done", 32'(n_done - d0), 32'd0);
    begin_test; fill(2);
    start_xfer("t6", 16'd0);
    send_block(0, 4, 512, 1'b0, 16'h0, 16'h0);
    wait_done("t6");
    verify_stream("t6");
    check("t6_blk_done", 32'(n_blkdone - bd0), 32'd1);
    check("t6_stop_req", 32'(n_stop - s0), 32'd0);
    check("t6_errs", 32'({m_errt, m_errc}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sd_dat_reader.md
Name: sd_dat_reader

Overview:
Parametrised SD data-phase receiver that generalises the single-sector, 1-bit DAT0 read path.
- Supports 1-bit or 4-bit bus width.
- Handles multi-block (CMD18-style) transfers of N sectors.
- Checks the CRC16 of each block on each lane.
- Applies a start-bit timeout.
- Sits beside the command controller: it samples DAT lines on rising edges of the controller-generated sdclk and streams sector bytes to the user side.

Parameters:
DAT_WIDTH, 1, bus width in bits; legal values 1 or 4.
TIMEOUT_CLKS, 1000000, sdclk rising edges to wait for a start bit before flagging timeout.
MAX_BLOCKS_W, 16, width of block-count and block-index fields.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
sdclk  in  1  SD clock from command controller (synchronous to clk)
sddat  in  DAT_WIDTH  SD DAT lines, sddat[0]=DAT0
start  in  1  one-cycle pulse; begin reception of nblocks blocks
nblocks  in  MAX_BLOCKS_W  block count, sampled on start; 0 treated as 1
abort  in  1  cancel reception immediately
busy  out  1  high from accepted start until done or abort
done  out  1  one-cycle pulse at end of transfer (success or error)
stop_req  out  1  one-cycle pulse with done when nblocks>1; tells cmd FSM to issue CMD12
err_timeout  out  1  sticky until next start; start bit not seen
err_crc  out  1  sticky until next start; CRC mismatch on any lane
blk_done  out  1  one-cycle pulse after each good block's end bit
blk_idx  out  MAX_BLOCKS_W  index of current block, 0-based
outen  out  1  one-cycle strobe: outbyte valid
outaddr  out  9  byte offset in sector, 0..511
outbyte  out  8  received byte

Behaviour:
- Reset: all outputs 0; FSM IDLE; counters and CRC registers cleared. Asserting rst mid-transfer abandons it with no done.
- Edge detect: sdclkl <= sdclk each clk. Sampling and all FSM data actions occur only on cycles where ~sdclkl & sdclk; abort and start act on any clk.
- States: IDLE, WAIT_START, DATA, CRC, END, DONE.
- IDLE: on start, latch nblocks (0->1), clear err flags, blk_idx=0, busy=1, go to WAIT_START. start while busy is ignored.
- WAIT_START:
  - Start bit = sddat[0]==0.
  - On start bit: go to DATA, clear the edge counter and the per-lane CRC registers.
  - Otherwise increment the counter. When it exceeds TIMEOUT_CLKS, set err_timeout and go to DONE.
- DATA:
  - Bits per lane = 4096/DAT_WIDTH.
  - 1-bit: MSB first, byte every 8 edges.
  - 4-bit: high nibble first (sddat[3] = bit 7/3), byte every 2 edges.
  - On the edge completing a byte, the next clk has outen=1, with outaddr = byte index and outbyte = that byte.
  - Each lane's bit feeds its own CRC16 (poly 0x1021, init 0x0000).
  - After the last data edge, go to CRC.
- CRC: 16 edges per lane, MSB first. Each lane's received bits are compared against its computed CRC; any mismatch sets err_crc. Then go to END.
- END: one edge (end bit, value not checked).
  - err_crc set: go to DONE.
  - Otherwise pulse blk_done.
  - If blk_idx+1 == latched count: go to DONE.
  - Else increment blk_idx and go to WAIT_START; the timeout counter restarts.
- DONE: one clk. done=1, stop_req=(count>1), busy=0, then IDLE. Error flags remain until next start.
- abort: any state goes to IDLE next clk, busy=0, no done/stop_req; flags unchanged. If abort and start occur in the same cycle, abort wins.
- outaddr wraps 511->0 between blocks; blk_idx distinguishes blocks.
- Bytes of a bad-CRC block are still streamed; the consumer must check err_crc before using them.

Decomposition:
- Package sd_pkg holds:
  - rx_state_t enum;
  - SD_SECTOR_BYTES=512, SD_CRC_BITS=16, SD_CRC16_POLY=16'h1021;
  - card_type constants (UNKNOWN, SDv1, SDv2, SDHCv2) shared with the command FSM.
- Sub-module sd_crc16: serial CRC16 with clear, enable and bit inputs and a 16-bit crc output, instantiated DAT_WIDTH times via generate.

Test Plan:
1. DAT_WIDTH=1, nblocks=1, start bit after 20 edges, 512x 8'hFF, CRC 16'h7FA1 -> 512 outen strobes all 8'hFF, outaddr 0..511, blk_done, done, err_crc=0, stop_req=0.
2. DAT_WIDTH=4, nblocks=3, incrementing bytes (addr[7:0]), correct per-lane CRCs from a bench model -> 1536 strobes, blk_idx 0,1,2, three blk_done, done with stop_req=1.
3. DAT_WIDTH=1, block 0 with one CRC bit flipped, nblocks=2 -> err_crc=1, no blk_done, done+stop_req after block 0, block 1 never received.
4. DAT lines held high, TIMEOUT_CLKS=100 -> done after 101 sdclk edges, err_timeout=1, no outen.
5. abort asserted at byte 200 of block 1 of 4 -> busy=0 next clk, no done; a following start is accepted and clears error flags.
6. rst pulsed asynchronously mid-DATA -> all outputs 0 immediately; a fresh 1-block read succeeds afterwards.
